branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 203 ++++++++++++++++++++
 tb/tb_branch_resolver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolver: keeps a program counter, captures comparator flags and
// resolves conditional branches against them, waiting a bounded number of
// cycles for flags when a branch arrives before its comparison result.
module branch_resolver #(
    parameter logic [7:0]  PC_RESET   = 8'h00,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmp_valid,
    input  logic [7:0] cmp_result,
    input  logic       step,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    input  logic [7:0] br_target,
    output logic       br_ready,
    output logic [7:0] pc,
    output logic       pc_load,
    output logic [2:0] flags,
    output logic       flags_vld,
    output logic       flag_err,
    output logic       timeout
);

    // Branch condition codes
    localparam logic [2:0] CondNever  = 3'b000;
    localparam logic [2:0] CondAlways = 3'b001;
    localparam logic [2:0] CondEq     = 3'b010;
    localparam logic [2:0] CondNe     = 3'b011;
    localparam logic [2:0] CondLt     = 3'b100;
    localparam logic [2:0] CondGt     = 3'b101;
    localparam logic [2:0] CondLe     = 3'b110;
    localparam logic [2:0] CondGe     = 3'b111;

    // Last wait-counter value before the wait is abandoned
    localparam logic [7:0] WaitLast = 8'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitFlags,
        StResolve
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       pc_load_q, pc_load_d;
    logic [2:0] flags_q, flags_d;
    logic       flags_vld_q, flags_vld_d;
    logic       flag_err_q, flag_err_d;
    logic       timeout_q, timeout_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] cond_q, cond_d;
    logic [7:0] target_q, target_d;

    logic       cmp_ok;
    logic       cmp_bad;
    logic       br_needs_flags;
    logic       cond_hit;

    // Evaluate a condition code against {GT,LT,EQ} flags
    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] f);
        logic r;
        r = 1'b0;
        unique case (cond)
            CondNever:  r = 1'b0;
            CondAlways: r = 1'b1;
            CondEq:     r = f[0];
            CondNe:     r = ~f[0];
            CondLt:     r = f[1];
            CondGt:     r = f[2];
            CondLe:     r = f[0] | f[1];
            CondGe:     r = f[0] | f[2];
        endcase
        return r;
    endfunction

    // Classify the comparator byte: upper bits clear and exactly one flag set
    always_comb begin
        cmp_ok  = 1'b0;
        cmp_bad = 1'b0;
        if (cmp_valid) begin
            if ((cmp_result[7:3] == 5'b0_0000) &&
                ((cmp_result[2:0] == 3'b001) ||
                 (cmp_result[2:0] == 3'b010) ||
                 (cmp_result[2:0] == 3'b100))) begin
                cmp_ok = 1'b1;
            end else begin
                cmp_bad = 1'b1;
            end
        end
    end

    // Only never/always branches can resolve without flags
    assign br_needs_flags = (br_cond != CondNever) && (br_cond != CondAlways);
    assign cond_hit       = cond_true(cond_q, flags_q);

    // Next-state logic for the FSM, pc and flag capture
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_load_d   = 1'b0;
        flags_d     = flags_q;
        flags_vld_d = flags_vld_q;
        flag_err_d  = flag_err_q;
        timeout_d   = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        cond_d      = cond_q;
        target_d    = target_q;

        // Flag capture is independent of the branch state
        if (cmp_ok) begin
            flags_d     = cmp_result[2:0];
            flags_vld_d = 1'b1;
        end
        if (cmp_bad) begin
            flag_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (br_valid) begin
                    cond_d     = br_cond;
                    target_d   = br_target;
                    wait_cnt_d = 8'd0;
                    if (!br_needs_flags || flags_vld_q || cmp_ok) begin
                        state_d = StResolve;
                    end else begin
                        state_d = StWaitFlags;
                    end
                end else if (step) begin
                    pc_d = pc_q + 8'd1;
                end
            end

            StWaitFlags: begin
                if (cmp_ok) begin
                    state_d    = StResolve;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WaitLast) begin
                    timeout_d  = 1'b1;
                    state_d    = StIdle;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            StResolve: begin
                if (cond_hit) begin
                    pc_d      = target_q;
                    pc_load_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                // Consumed flags are retired, but a fresh result arriving now wins
                if ((cond_q != CondNever) && (cond_q != CondAlways) && !cmp_ok) begin
                    flags_vld_d = 1'b0;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= PC_RESET;
            pc_load_q   <= 1'b0;
            flags_q     <= 3'b000;
            flags_vld_q <= 1'b0;
            flag_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
            cond_q      <= 3'b000;
            target_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_load_q   <= pc_load_d;
            flags_q     <= flags_d;
            flags_vld_q <= flags_vld_d;
            flag_err_q  <= flag_err_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
        end
    end

    assign br_ready  = (state_q == StIdle);
    assign pc        = pc_q;
    assign pc_load   = pc_load_q;
    assign flags     = flags_q;
    assign flags_vld = flags_vld_q;
    assign flag_err  = flag_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: per-cycle vectors with expected post-edge outputs,
// queued on drive and popped for comparison one time unit after the edge.
module tb_branch_resolver;

    logic       clk;
    logic       reset;
    logic       cmp_valid;
    logic [7:0] cmp_result;
    logic       step;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [7:0] br_target;
    logic       br_ready;
    logic [7:0] pc;
    logic       pc_load;
    logic [2:0] flags;
    logic       flags_vld;
    logic       flag_err;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [7:0] cr;
        logic       st;
        logic       bv;
        logic [2:0] bc;
        logic [7:0] bt;
        logic       rdy;
        logic [7:0] pc;
        logic       ld;
        logic [2:0] fl;
        logic       fv;
        logic       fe;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    branch_resolver #(
        .PC_RESET  (8'hFE),
        .WAIT_LIMIT(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmp_valid (cmp_valid),
        .cmp_result(cmp_result),
        .step      (step),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_target (br_target),
        .br_ready  (br_ready),
        .pc        (pc),
        .pc_load   (pc_load),
        .flags     (flags),
        .flags_vld (flags_vld),
        .flag_err  (flag_err),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic cv, input logic [7:0] cr, input logic st,
        input logic bv, input logic [2:0] bc, input logic [7:0] bt,
        input logic rdy, input logic [7:0] epc, input logic ld, input logic [2:0] fl,
        input logic fv, input logic fe, input logic to);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cr = cr; v.st = st;
        v.bv = bv; v.bc = bc; v.bt = bt;
        v.rdy = rdy; v.pc = epc; v.ld = ld; v.fl = fl;
        v.fv = fv; v.fe = fe; v.to = to;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, compare after the edge
    task automatic run_vec(input vec_t v, input string tag, input int idx);
        vec_t e;
        reset      = v.rst;
        cmp_valid  = v.cv;
        cmp_result = v.cr;
        step       = v.st;
        br_valid   = v.bv;
        br_cond    = v.bc;
        br_target  = v.bt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({br_ready, pc, pc_load, flags, flags_vld, flag_err, timeout} !==
            {e.rdy, e.pc, e.ld, e.fl, e.fv, e.fe, e.to}) begin
            errors++;
            $display("FAIL %s[%0d]: got rdy=%b pc=%02h ld=%b fl=%03b fv=%b fe=%b to=%b, expected rdy=%b pc=%02h ld=%b fl=%03b fv=%b fe=%b to=%b",
                     tag, idx, br_ready, pc, pc_load, flags, flags_vld, flag_err, timeout,
                     e.rdy, e.pc, e.ld, e.fl, e.fv, e.fe, e.to);
        end
    endtask

    initial begin
        reset = 1'b1; cmp_valid = 1'b0; cmp_result = 8'h00; step = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_target = 8'h00;

        //                rst cv cr     st bv bc      bt     rdy pc     ld fl      fv fe to
        // Reset, then step through the wrap
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 3'b000, 8'h00, 1, 8'hFF, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 3'b000, 8'h00, 1, 8'h00, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 3'b000, 8'h00, 1, 8'h01, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h01, 0, 3'b000, 0, 0, 0));
        // EQ flags first, then EQ branch (step ignored on accept)
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 3'b000, 8'h00, 1, 8'h01, 0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 3'b010, 8'h40, 0, 8'h01, 0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h40, 1, 3'b001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h40, 0, 3'b001, 0, 0, 0));
        // Always branch to 0x10, then same-cycle LT flags with GT branch
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 3'b001, 8'h10, 0, 8'h40, 0, 3'b001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h10, 1, 3'b001, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 1, 3'b101, 8'h20, 0, 8'h10, 0, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h11, 0, 3'b010, 0, 0, 0));
        // LT branch without flags: three wait cycles, br_valid/step ignored
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 3'b100, 8'h77, 0, 8'h11, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 3'b001, 8'h99, 0, 8'h11, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 0, 8'h11, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 0, 3'b000, 8'h00, 0, 8'h11, 0, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h77, 1, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h77, 0, 3'b010, 0, 0, 0));
        // Never branch falls through
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 3'b000, 8'h55, 0, 8'h77, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h78, 0, 3'b010, 0, 0, 0));
        // LE taken on LT
        tbl.push_back(mk(0, 1, 8'h02, 0, 1, 3'b110, 8'h30, 0, 8'h78, 0, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h30, 1, 3'b010, 0, 0, 0));
        // NE not taken on EQ
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 3'b000, 8'h00, 1, 8'h30, 0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 3'b011, 8'h50, 0, 8'h30, 0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'h31, 0, 3'b001, 0, 0, 0));
        // GE taken on GT
        tbl.push_back(mk(0, 1, 8'h04, 0, 1, 3'b111, 8'hA0, 0, 8'h31, 0, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hA0, 1, 3'b100, 0, 0, 0));
        // Always branch leaves valid flags in place; step wraps FF -> 00
        tbl.push_back(mk(0, 1, 8'h04, 0, 0, 3'b000, 8'h00, 1, 8'hA0, 0, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 3'b001, 8'hFF, 0, 8'hA0, 0, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFF, 1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 3'b000, 8'h00, 1, 8'h00, 0, 3'b100, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], "table", i);
        end

        // Malformed flags then a wait that times out on its 15th cycle
        run_vec(mk(1, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 0, 0), "to_reset", 0);
        run_vec(mk(0, 1, 8'h03, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 1, 0), "to_bad", 0);
        run_vec(mk(0, 0, 8'h00, 0, 1, 3'b010, 8'h40, 0, 8'hFE, 0, 3'b000, 0, 1, 0), "to_accept", 0);
        for (int c = 1; c <= 14; c++) begin
            logic [7:0] cr;
            cr = (c == 4) ? 8'h00 : ((c == 9) ? 8'h09 : 8'h03);
            run_vec(mk(0, (c == 4 || c == 9 || c == 12), cr, 1, 1, 3'b001, 8'h66,
                       0, 8'hFE, 0, 3'b000, 0, 1, 0), "to_wait", c);
        end
        run_vec(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 1, 1), "to_pulse", 15);
        run_vec(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 1, 0), "to_after", 16);
        run_vec(mk(0, 0, 8'h00, 1, 0, 3'b000, 8'h00, 1, 8'hFF, 0, 3'b000, 0, 1, 0), "to_step", 17);

        // Reset while waiting for flags aborts the branch
        run_vec(mk(0, 0, 8'h00, 0, 1, 3'b100, 8'h33, 0, 8'hFF, 0, 3'b000, 0, 1, 0), "abort_w", 0);
        run_vec(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 0, 8'hFF, 0, 3'b000, 0, 1, 0), "abort_w", 1);
        run_vec(mk(1, 1, 8'h02, 1, 1, 3'b001, 8'h12, 1, 8'hFE, 0, 3'b000, 0, 0, 0), "abort_w", 2);
        run_vec(mk(0, 1, 8'h02, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b010, 1, 0, 0), "abort_w", 3);
        run_vec(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b010, 1, 0, 0), "abort_w", 4);

        // Reset during the resolve cycle also suppresses the load
        run_vec(mk(0, 0, 8'h00, 0, 1, 3'b001, 8'h44, 0, 8'hFE, 0, 3'b010, 1, 0, 0), "abort_r", 0);
        run_vec(mk(1, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 0, 0), "abort_r", 1);
        run_vec(mk(0, 0, 8'h00, 0, 0, 3'b000, 8'h00, 1, 8'hFE, 0, 3'b000, 0, 0, 0), "abort_r", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
